// File: rtl/stream_to_mem_pkg.sv
// Shared definitions for the stream capture block: FSM encodings and state type.
package stream_to_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/stream_to_mem_if.sv
// Stream item interface between a stream source (master) and a consumer (slave).
// Handshake: an item transfers in any cycle where stream_rdy and stream_en are both high;
// stream_eos/stream_data are valid while stream_rdy is high, and the sink may drive
// stream_en combinationally from stream_rdy.
interface stream_to_mem_if #(
  parameter int datawidth = 8
) ();
  logic                 stream_rdy;
  logic                 stream_en;
  logic                 stream_eos;
  logic [datawidth-1:0] stream_data;

  modport master (output stream_rdy, stream_eos, stream_data, input stream_en);
  modport slave  (input stream_rdy, stream_eos, stream_data, output stream_en);
endinterface

// File: rtl/stream_to_mem.sv
// Captures a stream of items into memory from a base address until end-of-stream,
// bounded by a maximum word count; excess items are drained and flagged as overflow.
module stream_to_mem
  import stream_to_mem_pkg::*;
#(
  parameter int datawidth = 8,
  parameter int addrwidth = 10
) (
  input  logic                 oclk,
  input  logic                 oreset,
  stream_to_mem_if.slave       strm,
  input  logic                 start,
  input  logic [addrwidth-1:0] base_addr,
  input  logic [addrwidth:0]   max_len,
  output logic                 mem_we,
  output logic [addrwidth-1:0] mem_addr,
  output logic [datawidth-1:0] mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [addrwidth:0]   count,
  output state_t               dbg_state
);

  state_t               state_q, state_d;
  logic [addrwidth-1:0] base_q;
  logic [addrwidth:0]   max_q;
  logic                 capture;
  logic                 wr_en;
  logic                 ovf_set;

  always_ff @(posedge oclk or posedge oreset) begin
    if (oreset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    strm.stream_en = 1'b0;
    capture        = 1'b0;
    wr_en          = 1'b0;
    ovf_set        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        strm.stream_en = strm.stream_rdy;
        if (strm.stream_rdy) begin
          if (strm.stream_eos)  state_d = DONE;
          else if (count < max_q) wr_en = 1'b1;
          else begin
            ovf_set = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        strm.stream_en = strm.stream_rdy;
        if (strm.stream_rdy && strm.stream_eos) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write port is registered: an item consumed this cycle appears on mem_* next cycle.
  always_ff @(posedge oclk or posedge oreset) begin
    if (oreset) begin
      base_q    <= '0;
      max_q     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= wr_en;
      if (capture) begin
        base_q   <= base_addr;
        max_q    <= max_len;
        count    <= '0;
        overflow <= 1'b0;
      end
      if (wr_en) begin
        mem_addr  <= base_q + count[addrwidth-1:0];
        mem_wdata <= strm.stream_data;
        count     <= count + (addrwidth+1)'(1);
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stream_to_mem.sv
// Directed bench for stream_to_mem: table of per-cycle vectors plus reset sequences.
module tb_stream_to_mem;
  import stream_to_mem_pkg::*;

  localparam int DW = 8;
  localparam int AW = 10;

  logic          oclk = 1'b0;
  logic          oreset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   max_len;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy, done, overflow;
  logic [AW:0]   count;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;

  stream_to_mem_if #(.datawidth(DW)) sif ();

  stream_to_mem #(.datawidth(DW), .addrwidth(AW)) dut (
    .oclk      (oclk),
    .oreset    (oreset),
    .strm      (sif.slave),
    .start     (start),
    .base_addr (base_addr),
    .max_len   (max_len),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .count     (count),
    .dbg_state (dbg_state)
  );

  always #5 oclk = ~oclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string         name;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   maxl;
    logic          rdy;
    logic          eos;
    logic [DW-1:0] data;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_busy;
    logic          e_done;
    logic [AW:0]   e_count;
    logic          e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic st, input logic [AW-1:0] b, input logic [AW:0] ml,
                     input logic rdy, input logic eos, input logic [DW-1:0] d,
                     input logic en, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic bsy, input logic dn, input logic [AW:0] cnt, input logic ovf);
    vec_t v;
    v.name = nm; v.start = st; v.base = b; v.maxl = ml; v.rdy = rdy; v.eos = eos; v.data = d;
    v.e_en = en; v.e_we = we; v.e_addr = a; v.e_wdata = wd;
    v.e_busy = bsy; v.e_done = dn; v.e_count = cnt; v.e_ovf = ovf;
    tbl.push_back(v);
  endtask

  // Inputs change at the falling edge; stream_en is checked before the rising edge and
  // registered outputs just after it.
  task automatic run_row(input vec_t r);
    @(negedge oclk);
    start = r.start; base_addr = r.base; max_len = r.maxl;
    sif.stream_rdy = r.rdy; sif.stream_eos = r.eos; sif.stream_data = r.data;
    #1;
    chk({r.name, ".en"}, 32'(sif.stream_en), 32'(r.e_en));
    @(posedge oclk);
    #1;
    chk({r.name, ".we"}, 32'(mem_we), 32'(r.e_we));
    chk({r.name, ".busy"}, 32'(busy), 32'(r.e_busy));
    chk({r.name, ".done"}, 32'(done), 32'(r.e_done));
    chk({r.name, ".count"}, 32'(count), 32'(r.e_count));
    chk({r.name, ".ovf"}, 32'(overflow), 32'(r.e_ovf));
    if (r.e_we) begin
      chk({r.name, ".addr"}, 32'(mem_addr), 32'(r.e_addr));
      chk({r.name, ".wdata"}, 32'(mem_wdata), 32'(r.e_wdata));
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".en"}, 32'(sif.stream_en), 32'h0);
    chk({nm, ".we"}, 32'(mem_we), 32'h0);
    chk({nm, ".addr"}, 32'(mem_addr), 32'h0);
    chk({nm, ".wdata"}, 32'(mem_wdata), 32'h0);
    chk({nm, ".busy"}, 32'(busy), 32'h0);
    chk({nm, ".done"}, 32'(done), 32'h0);
    chk({nm, ".count"}, 32'(count), 32'h0);
    chk({nm, ".ovf"}, 32'(overflow), 32'h0);
    chk({nm, ".state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    // Wrap: base 3FE, max 8, A0 A1 A2 eos
    //   name        st base    max  rdy eos data   en we addr    wd     bsy dn cnt ovf
    add("wrap.start", 1, 10'h3FE, 11'd8, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 11'd0, 0);
    add("wrap.a0",    0, 10'h000, 11'd0, 1, 0, 8'hA0, 1, 1, 10'h3FE, 8'hA0, 1, 0, 11'd1, 0);
    add("wrap.a1",    0, 10'h000, 11'd0, 1, 0, 8'hA1, 1, 1, 10'h3FF, 8'hA1, 1, 0, 11'd2, 0);
    add("wrap.a2",    0, 10'h000, 11'd0, 1, 0, 8'hA2, 1, 1, 10'h000, 8'hA2, 1, 0, 11'd3, 0);
    add("wrap.eos",   0, 10'h000, 11'd0, 1, 1, 8'hEE, 1, 0, 10'h000, 8'h00, 1, 1, 11'd3, 0);
    add("wrap.idle",  0, 10'h000, 11'd0, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 11'd3, 0);
    add("wrap.hold",  0, 10'h000, 11'd0, 1, 0, 8'h77, 0, 0, 10'h000, 8'h00, 0, 0, 11'd3, 0);
    // Overflow: max 2, 11 22 33 44 eos
    add("ovf.start",  1, 10'h010, 11'd2, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 11'd0, 0);
    add("ovf.i11",    0, 10'h000, 11'd0, 1, 0, 8'h11, 1, 1, 10'h010, 8'h11, 1, 0, 11'd1, 0);
    add("ovf.i22",    0, 10'h000, 11'd0, 1, 0, 8'h22, 1, 1, 10'h011, 8'h22, 1, 0, 11'd2, 0);
    add("ovf.i33",    0, 10'h000, 11'd0, 1, 0, 8'h33, 1, 0, 10'h000, 8'h00, 1, 0, 11'd2, 1);
    add("ovf.i44",    0, 10'h000, 11'd0, 1, 0, 8'h44, 1, 0, 10'h000, 8'h00, 1, 0, 11'd2, 1);
    add("ovf.eos",    0, 10'h000, 11'd0, 1, 1, 8'h00, 1, 0, 10'h000, 8'h00, 1, 1, 11'd2, 1);
    add("ovf.idle",   0, 10'h000, 11'd0, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 11'd2, 1);
    // Stall: rdy toggles; stall cycles carry junk eos/data that must be ignored
    add("stl.start",  1, 10'h020, 11'd8, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 11'd0, 0);
    add("stl.d1",     0, 10'h000, 11'd0, 1, 0, 8'hC1, 1, 1, 10'h020, 8'hC1, 1, 0, 11'd1, 0);
    add("stl.s1",     0, 10'h000, 11'd0, 0, 1, 8'hFF, 0, 0, 10'h000, 8'h00, 1, 0, 11'd1, 0);
    add("stl.d2",     0, 10'h000, 11'd0, 1, 0, 8'hC2, 1, 1, 10'h021, 8'hC2, 1, 0, 11'd2, 0);
    add("stl.s2",     0, 10'h000, 11'd0, 0, 1, 8'hFF, 0, 0, 10'h000, 8'h00, 1, 0, 11'd2, 0);
    add("stl.d3",     0, 10'h000, 11'd0, 1, 0, 8'hC3, 1, 1, 10'h022, 8'hC3, 1, 0, 11'd3, 0);
    add("stl.s3",     0, 10'h000, 11'd0, 0, 0, 8'hFF, 0, 0, 10'h000, 8'h00, 1, 0, 11'd3, 0);
    add("stl.d4",     0, 10'h000, 11'd0, 1, 0, 8'hC4, 1, 1, 10'h023, 8'hC4, 1, 0, 11'd4, 0);
    add("stl.s4",     0, 10'h000, 11'd0, 0, 1, 8'hFF, 0, 0, 10'h000, 8'h00, 1, 0, 11'd4, 0);
    add("stl.eos",    0, 10'h000, 11'd0, 1, 1, 8'h00, 1, 0, 10'h000, 8'h00, 1, 1, 11'd4, 0);
    add("stl.idle",   0, 10'h000, 11'd0, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 11'd4, 0);
    // Start during RUN is ignored (base and max stay as latched)
    add("ign.start",  1, 10'h200, 11'd8, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 11'd0, 0);
    add("ign.d1",     0, 10'h000, 11'd0, 1, 0, 8'h01, 1, 1, 10'h200, 8'h01, 1, 0, 11'd1, 0);
    add("ign.d2st",   1, 10'h100, 11'd1, 1, 0, 8'h02, 1, 1, 10'h201, 8'h02, 1, 0, 11'd2, 0);
    add("ign.d3",     0, 10'h000, 11'd0, 1, 0, 8'h03, 1, 1, 10'h202, 8'h03, 1, 0, 11'd3, 0);
    add("ign.eos",    0, 10'h000, 11'd0, 1, 1, 8'h00, 1, 0, 10'h000, 8'h00, 1, 1, 11'd3, 0);
    add("ign.idle",   0, 10'h000, 11'd0, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 11'd3, 0);
    // max_len 0: first data item overflows
    add("z.start",    1, 10'h050, 11'd0, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 11'd0, 0);
    add("z.d55",      0, 10'h000, 11'd0, 1, 0, 8'h55, 1, 0, 10'h000, 8'h00, 1, 0, 11'd0, 1);
    add("z.eos",      0, 10'h000, 11'd0, 1, 1, 8'h00, 1, 0, 10'h000, 8'h00, 1, 1, 11'd0, 1);
    add("z.idle",     0, 10'h000, 11'd0, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 11'd0, 1);

    oreset = 1'b1; start = 1'b0; base_addr = '0; max_len = '0;
    sif.stream_rdy = 1'b1; sif.stream_eos = 1'b0; sif.stream_data = 8'h5A;
    #3;
    chk_reset_outputs("por");
    @(negedge oclk);
    oreset = 1'b0;
    sif.stream_rdy = 1'b0;

    foreach (tbl[i]) run_row(tbl[i]);

    // Reset mid-capture after two items, with a third item on the bus
    tbl.delete();
    add("rst.start",  1, 10'h300, 11'd8, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 11'd0, 0);
    add("rst.d1",     0, 10'h000, 11'd0, 1, 0, 8'h91, 1, 1, 10'h300, 8'h91, 1, 0, 11'd1, 0);
    add("rst.d2",     0, 10'h000, 11'd0, 1, 0, 8'h92, 1, 1, 10'h301, 8'h92, 1, 0, 11'd2, 0);
    foreach (tbl[i]) run_row(tbl[i]);

    @(negedge oclk);
    sif.stream_rdy = 1'b1; sif.stream_eos = 1'b0; sif.stream_data = 8'h93;
    #2;
    oreset = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge oclk);
    #1;
    chk("mid_rst.we_after_edge", 32'(mem_we), 32'h0);
    chk("mid_rst.count_after_edge", 32'(count), 32'h0);
    @(negedge oclk);
    oreset = 1'b0;
    #1;
    chk("post_rst.en", 32'(sif.stream_en), 32'h0);
    @(posedge oclk);
    #1;
    chk("post_rst.we", 32'(mem_we), 32'h0);
    chk("post_rst.busy", 32'(busy), 32'h0);

    tbl.delete();
    add("new.start",  1, 10'h040, 11'd8, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 11'd0, 0);
    add("new.d1",     0, 10'h000, 11'd0, 1, 0, 8'h0A, 1, 1, 10'h040, 8'h0A, 1, 0, 11'd1, 0);
    add("new.eos",    0, 10'h000, 11'd0, 1, 1, 8'h00, 1, 0, 10'h000, 8'h00, 1, 1, 11'd1, 0);
    add("new.idle",   0, 10'h000, 11'd0, 0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 11'd1, 0);
    foreach (tbl[i]) run_row(tbl[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
